// File: rtl/y_buf_pkg.sv
// Shared constants and state encoding for the Y buffer reader.
package y_buf_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int ADDR_STRIDE     = 4;
   localparam int CLS_W           = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      OUT,
      DONE
   } state_e;

endpackage

// File: rtl/argmax_unit.sv
// Streaming signed argmax: one score per valid cycle, first sample loads, later samples win only if strictly greater.
module argmax_unit
   import y_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic                  first_i,
   input  logic                  last_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  final_o,
   output logic [CLS_W-1:0]      idx_o,
   output logic [DATA_WIDTH-1:0] max_o
);

   logic [CLS_W-1:0] pos_q;
   logic             take;

   // Strict compare keeps the lowest index on ties.
   assign take    = first_i || ($signed(data_i) > $signed(max_o));
   assign final_o = valid_i && last_i;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_q <= '0;
         idx_o <= '0;
         max_o <= '0;
      end else if (valid_i) begin
         pos_q <= first_i ? CLS_W'(1) : pos_q + 1'b1;
         if (take) begin
            max_o <= data_i;
            idx_o <= first_i ? '0 : pos_q;
         end
      end
   end

endmodule

// File: rtl/y_buf_reader.sv
// Walks every image in the Y buffer, reads its class scores and reports the signed argmax per image.
// Optional Y_RD_SCORE_OUT_EN exports the winning score on res_score_o.
module y_buf_reader
   import y_buf_pkg::*;
#(
   parameter int                    IN_IMG_NUM  = 10,
   parameter int                    NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  y_rd_en_o,
   output logic [ADDR_WIDTH-1:0] y_rd_addr_o,
   input  logic [DATA_WIDTH-1:0] y_rd_data_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [3:0]            res_class_o,
   output logic [7:0]            res_img_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef Y_RD_SCORE_OUT_EN
   ,
   output logic [DATA_WIDTH-1:0] res_score_o
`endif
);

   localparam logic [CLS_W-1:0] K_LAST   = CLS_W'(NUM_CLASSES - 1);
   localparam logic [7:0]       IMG_LAST = 8'(IN_IMG_NUM - 1);

   state_e                  state_q, state_d;
   logic [CLS_W-1:0]        k_q;
   logic [7:0]              img_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    rd_vld_q, rd_first_q, rd_last_q;
   logic                    arg_final;
   logic [CLS_W-1:0]        arg_idx;
   logic [DATA_WIDTH-1:0]   arg_max;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      y_rd_en_o   = 1'b0;
      res_valid_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         IDLE:  if (start_i) state_d = READ;
         READ: begin
            y_rd_en_o = 1'b1;
            busy_o    = 1'b1;
            if (k_q == K_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (arg_final) state_d = OUT;
         end
         OUT: begin
            res_valid_o = 1'b1;
            busy_o      = 1'b1;
            if (res_ready_i) state_d = (img_q == IMG_LAST) ? DONE : READ;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         k_q        <= '0;
         img_q      <= '0;
         addr_q     <= '0;
         rd_vld_q   <= 1'b0;
         rd_first_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Read data lags the enable by one cycle; tag it on the same delay.
         rd_vld_q   <= (state_q == READ);
         rd_first_q <= (state_q == READ) && (k_q == '0);
         rd_last_q  <= (state_q == READ) && (k_q == K_LAST);
         case (state_q)
            IDLE: if (start_i) begin
               img_q  <= '0;
               k_q    <= '0;
               addr_q <= BASE_ADDR;
            end
            READ: begin
               addr_q <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
               k_q    <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end
            OUT: if (res_ready_i && (img_q != IMG_LAST)) img_q <= img_q + 1'b1;
            default: ;
         endcase
      end
   end

   argmax_unit #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_argmax (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (rd_vld_q),
      .first_i (rd_first_q),
      .last_i  (rd_last_q),
      .data_i  (y_rd_data_i),
      .final_o (arg_final),
      .idx_o   (arg_idx),
      .max_o   (arg_max)
   );

   assign y_rd_addr_o = addr_q;
   assign res_class_o = arg_idx;
   assign res_img_o   = img_q;

`ifdef Y_RD_SCORE_OUT_EN
   assign res_score_o = arg_max;
`else
   logic [DATA_WIDTH-1:0] unused_max;
   assign unused_max = arg_max;
`endif

endmodule

// File: tb/tb_y_buf_reader.sv
// Directed bench for y_buf_reader: BRAM model, per-image argmax vectors, backpressure, busy restart and mid-read reset.
module tb_y_buf_reader;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b1;
   logic          start_i     = 1'b0;
   logic          res_ready_i = 1'b0;
   logic          y_rd_en_o;
   logic [AW-1:0] y_rd_addr_o;
   logic [DW-1:0] y_rd_data_i = '0;
   logic          res_valid_o;
   logic [3:0]    res_class_o;
   logic [7:0]    res_img_o;
   logic          busy_o;
   logic          done_o;
`ifdef Y_RD_SCORE_OUT_EN
   logic [DW-1:0] res_score_o;
   logic [DW-1:0] exp_score [10] = '{32'd1000, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'd100, 32'd5,
                                     32'd1, 32'h4000_0000, 32'd42, 32'h7FFF_FFFF, 32'd7};
`endif

   logic [3:0]    exp_cls [10] = '{4'd7, 4'd3, 4'd2, 4'd0, 4'd9, 4'd5, 4'd4, 4'd0, 4'd1, 4'd6};
   logic [DW-1:0] mem [0:127];

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            t_start = 0;
   int            rd_cnt = 0;
   int            rd_base = 0;
   int            addr_err = 0;
   int            hs_cnt = 0;
   int            done_cnt = 0;
   logic [AW-1:0] last_addr = '0;

   y_buf_reader dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .y_rd_en_o   (y_rd_en_o),
      .y_rd_addr_o (y_rd_addr_o),
      .y_rd_data_i (y_rd_data_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_class_o (res_class_o),
      .res_img_o   (res_img_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
`ifdef Y_RD_SCORE_OUT_EN
      ,
      .res_score_o (res_score_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // BRAM read port: one-cycle latency
   always @(posedge clk_i) if (y_rd_en_o) y_rd_data_i <= mem[y_rd_addr_o[8:2]];

   always @(negedge clk_i) begin
      if (y_rd_en_o) begin
         if (y_rd_addr_o !== AW'((rd_cnt - rd_base) * 4)) addr_err = addr_err + 1;
         last_addr = y_rd_addr_o;
         rd_cnt    = rd_cnt + 1;
      end
      if (res_valid_o && res_ready_i) hs_cnt = hs_cnt + 1;
      if (done_o) done_cnt = done_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rd_en"},   y_rd_en_o,   1'b0);
      check({tag, "_rd_addr"}, y_rd_addr_o, 32'd0);
      check({tag, "_valid"},   res_valid_o, 1'b0);
      check({tag, "_class"},   res_class_o, 4'd0);
      check({tag, "_img"},     res_img_o,   8'd0);
      check({tag, "_busy"},    busy_o,      1'b0);
      check({tag, "_done"},    done_o,      1'b0);
`ifdef Y_RD_SCORE_OUT_EN
      check({tag, "_score"},   res_score_o, 32'd0);
`endif
   endtask

   task automatic pulse_start();
      @(posedge clk_i); #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      t_start = cyc;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!res_valid_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check(tag, res_valid_o, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] cls_hold;
      logic       held_bad;

      for (int k = 0; k < 128; k++) mem[k] = '0;
      for (int k = 0; k < 10; k++) begin
         mem[k]      = (k == 7) ? 32'd1000 : 32'd0;
         mem[10 + k] = (k == 3) ? 32'hFFFF_FFFB : 32'(-6 - k);
         mem[20 + k] = (k == 2 || k == 8) ? 32'h7FFF_FFFF : 32'd0;
         mem[30 + k] = (k == 0) ? 32'd100 : 32'd99;
         mem[40 + k] = (k == 9) ? 32'd5 : 32'd0;
         mem[50 + k] = (k == 5) ? 32'd1 : 32'hFFFF_FFFF;
         mem[60 + k] = (k == 4) ? 32'h4000_0000 : 32'(k);
         mem[70 + k] = 32'd42;
         mem[80 + k] = (k == 1) ? 32'h7FFF_FFFF : ((k == 6) ? 32'h8000_0000 : 32'd0);
         mem[90 + k] = (k == 6) ? 32'd7 : 32'd0;
      end

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_reset("reset");
      @(posedge clk_i); #1 rst_i = 1'b0;
      res_ready_i = 1'b1;

      rd_base = rd_cnt;
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         if (i == 6) begin
            @(posedge clk_i); #1 start_i = 1'b1;
            @(posedge clk_i); #1 start_i = 1'b0;
         end
         wait_valid($sformatf("img%0d_valid", i));
         if (i == 0) begin
            check("img0_latency",   cyc + 1 - t_start, 12);
            check("img0_reads",     rd_cnt - rd_base, 10);
            check("img0_last_addr", last_addr, 32'd36);
         end
         check($sformatf("img%0d_class", i), res_class_o, exp_cls[i]);
         check($sformatf("img%0d_img", i),   res_img_o,   8'(i));
         check($sformatf("img%0d_busy", i),  busy_o,      1'b1);
`ifdef Y_RD_SCORE_OUT_EN
         check($sformatf("img%0d_score", i), res_score_o, exp_score[i]);
`endif
         if (i == 3) begin
            @(posedge clk_i); #1 res_ready_i = 1'b0;
         end
         if (i == 4) begin
            cls_hold = res_class_o;
            held_bad = 1'b0;
            repeat (20) begin
               @(negedge clk_i);
               if (!res_valid_o || res_class_o !== cls_hold || res_img_o !== 8'd4 || y_rd_en_o)
                  held_bad = 1'b1;
            end
            check("img4_hold_stable", held_bad, 1'b0);
            check("img4_no_reads", rd_cnt - rd_base, 50);
            @(posedge clk_i); #1 res_ready_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            check("img5_first_rd_en",   y_rd_en_o,   1'b1);
            check("img5_first_rd_addr", y_rd_addr_o, 32'd200);
            check("img5_valid_low",     res_valid_o, 1'b0);
         end
      end

      @(negedge clk_i);
      check("done_pulse",     done_o, 1'b1);
      check("done_busy_low",  busy_o, 1'b0);
      @(negedge clk_i);
      check("done_one_cycle", done_o, 1'b0);
      check("idle_valid_low", res_valid_o, 1'b0);
      check("total_reads",    rd_cnt - rd_base, 100);
      check("final_addr",     last_addr, 32'd396);
      check("handshakes",     hs_cnt, 10);
      check("done_count",     done_cnt, 1);
      check("addr_sequence",  addr_err, 0);

      rd_base = rd_cnt;
      pulse_start();
      repeat (4) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("abort");
      repeat (15) @(negedge clk_i);
      check("abort_no_result", hs_cnt, 10);
      check("abort_no_done",   done_cnt, 1);

      rd_base = rd_cnt;
      pulse_start();
      wait_valid("restart_valid");
      check("restart_latency", cyc + 1 - t_start, 12);
      check("restart_reads",   rd_cnt - rd_base, 10);
      check("restart_class",   res_class_o, 4'd7);
      check("restart_img",     res_img_o, 8'd0);
      check("restart_addr",    addr_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/y_buf_reader.md
# y_buf_reader

Reads back the per-image class scores that the inference pipeline writes into the output Y buffer, and reduces each image's scores to a predicted class. Sits on the read port of the Y buffer BRAM, downstream of the pipeline's done interrupt. It walks all images sequentially, issues one BRAM read per class score and computes a signed argmax. Each result is presented on a valid/ready interface to the reporting logic (LED/UART/PS).

## Interface
- IN_IMG_NUM, 10, number of images stored in the Y buffer
- NUM_CLASSES, 10, scores per image
- DATA_WIDTH, 32, score width (signed two's complement)
- ADDR_WIDTH, 32, Y buffer address width (byte address)
- BASE_ADDR, 0, byte address of image 0 class 0

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  single-cycle start pulse (pipeline done interrupt)
- y_rd_en_o  out  1  Y buffer read enable
- y_rd_addr_o  out  ADDR_WIDTH  Y buffer byte address
- y_rd_data_i  in  DATA_WIDTH  Y buffer read data, valid one cycle after y_rd_en_o
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted when high with res_valid_o
- res_class_o  out  4  argmax class index 0..NUM_CLASSES-1
- res_img_o  out  8  image index 0..IN_IMG_NUM-1
- res_score_o  out  DATA_WIDTH  winning score (only with Y_RD_SCORE_OUT_EN)
- busy_o  out  1  high from start acceptance until done_o
- done_o  out  1  one-cycle pulse after last result accepted

## Operation
- States: IDLE, READ, DRAIN, OUT, DONE.
- IDLE: start_i high -> READ, image counter = 0. start_i in any other state ignored.
- READ: y_rd_en_o high for NUM_CLASSES consecutive cycles, class counter k = 0..NUM_CLASSES-1; address = BASE_ADDR + (img*NUM_CLASSES + k)*4. After k = NUM_CLASSES-1 -> DRAIN.
- DRAIN: y_rd_en_o low; last score compared; -> OUT.
- Argmax: data for class 0 loads max unconditionally; class k>0 replaces max only if strictly greater (signed). Ties resolve to the lowest index.
- OUT: res_valid_o high, res_* stable until res_valid_o & res_ready_i. On handshake: last image -> DONE, else image+1 -> READ.
- DONE: done_o high one cycle -> IDLE.
- Default geometry: addresses 0..396 step 4, 100 reads total.
- Reset: all state to IDLE, counters 0. Reset values: y_rd_en_o 0, y_rd_addr_o 0, res_valid_o 0, res_class_o 0, res_img_o 0, res_score_o 0, busy_o 0, done_o 0. Reset mid-read or mid-OUT abandons the pass; no result and no done_o emitted.

## Timing
- start_i sampled high at edge T: reads issued at cycles T+1..T+NUM_CLASSES; score k returns at T+2+k.
- res_valid_o rises at T+NUM_CLASSES+2 (T+12 default).
- Handshake at edge H: next image's first read at H+1, its res_valid_o at H+NUM_CLASSES+2. Per-image cost with res_ready_i held high: NUM_CLASSES+2 cycles.
- done_o at cycle after final handshake; busy_o falls in the same cycle as done_o. IDLE accepts start_i the following cycle.
- res_ready_i high while res_valid_o low has no effect.

## Configuration
- Y_RD_SCORE_OUT_EN defined: res_score_o port present; it carries the signed winning score, registered with res_class_o.
- Not defined: port absent. The max register still exists for comparison, but its value is not exported.

## Structure
- Package y_buf_pkg: NUM_CLASSES default, address stride constant (4), state enum typedef, class index width.
- Sub-module argmax_unit: streaming signed compare with first/valid/last inputs; outputs index and max. The FSM and address generation stay in y_buf_reader.

## Test plan
- Default params, res_ready_i tied high, image 0 scores all 0 except class 7 = 1000 -> res_class_o 7, res_img_o 0, res_valid_o at T+12, addresses 0..36.
- All scores negative, class 3 = -5, others ≤ -6 -> class 3 (signed compare, not unsigned).
- Tie: classes 2 and 8 both 0x7FFFFFFF -> class 2.
- res_ready_i low for 20 cycles on image 4 -> res_* held stable, no reads issued, image 5 reads start cycle after handshake.
- Full 10-image run -> 100 reads, last address 396, exactly 10 handshakes, done_o single pulse, second start_i during busy ignored.
- rst_i asserted on cycle 5 of the READ state -> next cycle all outputs at reset values; a new start_i restarts at address 0.
